// File: rtl/pipo_arbiter_pkg.sv
// pipo_arbiter_pkg
//   Shared definitions for the PIPO arbiter slice: the FSM state encoding and
//   a constant-evaluable clog2 used to size the owner index and hold counter.
package pipo_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Ceiling log2; clog2(1) == 0, so callers clamp to at least 1 bit themselves.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < v) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pipo_arbiter_rr_select.sv
// pipo_arbiter_rr_select
//   Purely combinational round-robin picker.
//   req        : level requests, bit i = requester i
//   rr_ptr     : requester that currently has highest priority
//   any        : at least one request is set
//   win_idx    : first set request scanning upward from rr_ptr, wrapping
//   win_onehot : one-hot form of win_idx (all zero when any==0)
module pipo_arbiter_rr_select #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic            any,
  output logic [PW-1:0]   win_idx,
  output logic [NREQ-1:0] win_onehot
);

  // Scan offsets from the far end down to 0 so the closest request to rr_ptr
  // is the last one written and therefore wins.
  always_comb begin
    any        = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int c;
      c = (int'(rr_ptr) + k) % NREQ;
      if (req[c]) begin
        any        = 1'b1;
        win_idx    = PW'(c);
        win_onehot = NREQ'(1) << c;
      end else begin
        any        = any;
      end
    end
  end

endmodule

// File: rtl/pipo_arbiter.sv
// pipo_arbiter
//   Round-robin arbiter that loads one requester's word into a shared PIPO
//   register and flags it valid for HOLD_CYCLES cycles.
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   req          : per-requester level request
//   data_in      : flattened words, requester i at [i*WIDTH +: WIDTH]
//   grant        : one-cycle one-hot pulse to the winner
//   parallel_out : shared register contents (kept through IDLE)
//   owner        : index of the last granted requester
//   out_valid    : parallel_out holds a freshly granted word
//   busy         : in HOLD, requests are ignored
module pipo_arbiter
  import pipo_arbiter_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 2,
  localparam int OWW        = (clog2(NREQ) > 1) ? clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data_in,
  output logic [NREQ-1:0]       grant,
  output logic [WIDTH-1:0]      parallel_out,
  output logic [OWW-1:0]        owner,
  output logic                  out_valid,
  output logic                  busy
);

  localparam int CW = (clog2(HOLD_CYCLES + 1) > 1) ? clog2(HOLD_CYCLES + 1) : 1;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [OWW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [WIDTH-1:0]  pout_q, pout_d;
  logic [OWW-1:0]    owner_q, owner_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  logic              sel_any_s;
  logic [OWW-1:0]    sel_idx_s;
  logic [NREQ-1:0]   sel_onehot_s;

  pipo_arbiter_rr_select #(
    .NREQ (NREQ),
    .PW   (OWW)
  ) u_rr_select (
    .req        (req),
    .rr_ptr     (rr_ptr_q),
    .any        (sel_any_s),
    .win_idx    (sel_idx_s),
    .win_onehot (sel_onehot_s)
  );

  // Next-state and output-register logic; grant defaults low so it pulses once.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = '0;
    pout_d   = pout_q;
    owner_d  = owner_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_any_s) begin
          pout_d   = data_in[int'(sel_idx_s) * WIDTH +: WIDTH];
          owner_d  = sel_idx_s;
          grant_d  = sel_onehot_s;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          cnt_d    = CW'(HOLD_CYCLES);
          state_d  = ST_HOLD;
          // Winner drops to lowest priority for the next round.
          if (sel_idx_s == OWW'(NREQ - 1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = sel_idx_s + OWW'(1);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counter, pointer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      pout_q   <= '0;
      owner_q  <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      pout_q   <= pout_d;
      owner_q  <= owner_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign grant        = grant_q;
  assign parallel_out = pout_q;
  assign owner        = owner_q;
  assign out_valid    = valid_q;
  assign busy         = busy_q;

endmodule
